irq_arbiter: RTL
================

Name: irq_arbiter

Overview:
- Interrupt controller sitting between up to 8 peripheral interrupt sources and the core's single `int` input.
- Latches rising edges per source, applies a software mask, and picks one pending source by round-robin.
- Drives `int` and presents the granted source ID on the core's 8-bit I/O input path.
- The core configures the block and acknowledges interrupts through its existing ioout/iowrite/ioread port.

Parameters:
- NSRC, 4, number of interrupt sources (1..8).
- IDW, 3, width of the source ID field (fixed 3; supports 8 sources).

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq  in  NSRC  level interrupt lines from peripherals; already synchronous to clock.
- sel  in  1  external address decode: this device is the current I/O target.
- ioout  in  8  core I/O write data.
- iowrite  in  1  core I/O write strobe; effective when sel=1.
- ioread  in  1  core I/O read strobe; effective when sel=1.
- iodata  out  8  read data to core ioin mux; valid while sel=1.
- int  out  1  interrupt request to core; registered.

Behaviour:
- Reset (reset=0, async) clears all state:
  - irq_q=0, pending=0, mask=0 (all masked), rr_ptr=0, grant=0.
  - state=IDLE, int=0.
- Edge capture: irq_q <= irq every cycle. rise[i] = irq[i] & ~irq_q[i].
  - rise[i] sets pending[i] on the next edge.
  - An edge on an already-pending source is absorbed; there is no counting.
- Write decode, when sel & iowrite, by ioout[7]:
  - ioout[7]=0: mask <= ioout[NSRC-1:0].
  - ioout[7]=1: pending[i] <= 0 for each ioout[i]=1 (write-1-to-clear).
  - Set beats clear: if rise[i] occurs in the same cycle as a clear of bit i, pending[i] ends at 1.
- Eligible set: elig = pending & mask.
- Round-robin pick: lowest index i >= rr_ptr with elig[i]; if none, wrap to the lowest index < rr_ptr.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: int=0.
    - If elig != 0: grant <= pick, state <= ASSERT, int <= 1. int is seen high 1 cycle after elig becomes nonzero.
  - ASSERT: int=1; grant is held stable.
    - Ack is sel & ioread. On ack: pending[grant] <= 0 (unless rise[grant] that cycle), rr_ptr <= grant+1 mod NSRC, state <= GAP, int <= 0.
    - Withdraw: if mask[grant]=0 or pending[grant]=0 (cleared by software) with no ack, state <= IDLE, int <= 0, rr_ptr unchanged.
    - If ack and withdraw coincide, ack wins.
  - GAP: int=0 for exactly one cycle, then state <= IDLE. This guarantees the core sees a low between requests.
- Read data (combinational, sel=1):
  - iodata = {valid, 4'b0, grant[2:0]}, with valid=1 only in ASSERT. In IDLE/GAP: 0x00.
  - sel=0: iodata=0x00.
- Read/write precedence: iowrite and ioread both asserted with sel is illegal; the write is performed and the ack is suppressed.
- Bits of ioout[6:NSRC] are ignored. Unused mask/pending bits (index >= NSRC) read as 0.
- Reset mid-ASSERT: int drops immediately (asynchronously); pending is lost.

Decomposition:
- Shared package irq_pkg holds:
  - state encoding (IDLE=2'd0, ASSERT=2'd1, GAP=2'd2);
  - CMD_MASK=1'b0 and CMD_CLR=1'b1 (the ioout[7] meanings);
  - VALID_BIT=7 and ID width IDW=3.
- One sub-module, rr_pick: combinational round-robin selector. Inputs req[NSRC] and ptr; outputs any and idx[IDW]. It is instanced once and tested standalone over all req/ptr combinations.

Test Plan:
- Reset, write mask 0x0F, pulse irq[2] 0->1 -> int=1 two cycles later; read with sel -> iodata=0x82; int=0 for one cycle (GAP); pending=0.
- Mask 0x0F, irq[0] and irq[3] rise in the same cycle, rr_ptr=0:
  - first read returns 0x80; int returns after GAP+IDLE;
  - second read returns 0x83;
  - then repeat with both rising again -> first grant is 0x80 (rr_ptr wrapped to 0 after granting 3).
- irq[1] rises with mask=0x00 -> int stays 0. Write mask 0x02 -> int=1 one cycle later; iodata=0x81.
- In ASSERT with grant=1, write 0x00 (mask all) -> int=0 next cycle, state IDLE, iodata=0x00; pending[1] still 1. Rewrite mask 0x02 -> int reasserts.
- Write clear 0x84 in the same cycle irq[2] rises -> pending[2]=1 and int asserts.
- Drop reset low during ASSERT -> int=0 immediately; after release, read returns 0x00 and mask=0.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared encodings for the interrupt arbiter: FSM states,
//                ioout[7] command meanings, and the read-data layout.
//  Revision    : 1.0  initial release
// ============================================================================
package irq_pkg;

    // Width of the source ID field; supports up to 8 sources.
    localparam int IDW       = 3;

    // Bit of iodata that flags a live grant.
    localparam int VALID_BIT = 7;

    // ioout[7] meaning on a write.
    localparam logic CMD_MASK = 1'b0;
    localparam logic CMD_CLR  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Returns the lowest
//                requesting index at or above ptr, else wraps to the lowest
//                requesting index below ptr.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import irq_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    // Wrap candidate first (lowest overall), then let the lowest index at or
    // above ptr override it when one exists.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDW'(i);
            end
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i] && (IDW'(i) >= ptr)) begin
                idx = IDW'(i);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arbiter
//  Description : Interrupt controller for up to 8 level sources. Latches
//                rising edges, applies a software mask, round-robin selects
//                one eligible source, drives the core's interrupt line and
//                exposes the granted ID on the core's I/O read path.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic            sel,
    input  logic [7:0]      ioout,
    input  logic            iowrite,
    input  logic            ioread,
    output logic [7:0]      iodata,
    // Interrupt request to the core; "int" is a reserved word in SV.
    output logic            intr
);

    logic [NSRC-1:0] r_irq_q;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_grant;
    logic            r_int;
    state_t          r_state;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_gnt_oh;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_mask_nxt;
    logic            w_wr;
    logic            w_ack;
    logic            w_any;
    logic [IDW-1:0]  w_pick;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [IDW-1:0]  w_grant_nxt;
    state_t          w_state_nxt;
    logic            w_unused;

    assign w_rise   = irq & ~r_irq_q;
    assign w_elig   = r_pend & r_mask;
    assign w_gnt_oh = NSRC'(1) << r_grant;
    assign w_wr     = sel & iowrite;
    // A simultaneous write wins, so the read strobe is not an ack then.
    assign w_ack    = sel & ioread & ~iowrite & (r_state == ASSERT);
    // ioout bits between the source field and the command bit carry nothing.
    assign w_unused = &{1'b0, ioout};

    rr_pick #(
        .NSRC (NSRC)
    ) u_rr_pick (
        .req (w_elig),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    // Next mask/pending: software write, ack clear, then edge set on top.
    always_comb begin
        w_mask_nxt = r_mask;
        w_pend_nxt = r_pend;
        if (w_wr) begin
            if (ioout[7] == CMD_MASK) begin
                w_mask_nxt = ioout[NSRC-1:0];
            end else begin
                w_pend_nxt = w_pend_nxt & ~ioout[NSRC-1:0];
            end
        end
        if (w_ack) begin
            w_pend_nxt = w_pend_nxt & ~w_gnt_oh;
        end
        w_pend_nxt = w_pend_nxt | w_rise;
    end

    // Arbitration FSM next state; withdraw looks at this cycle's updates so
    // a mask or clear write drops the request on the following edge.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ASSERT;
                    w_grant_nxt = w_pick;
                end
            end
            ASSERT: begin
                if (w_ack) begin
                    w_state_nxt = GAP;
                    w_ptr_nxt   = (r_grant == IDW'(NSRC - 1)) ? '0
                                                             : r_grant + IDW'(1);
                end else if ((w_mask_nxt & w_pend_nxt & w_gnt_oh) == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, edge capture and configuration registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_irq_q <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_int   <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_irq_q <= irq;
            r_pend  <= w_pend_nxt;
            r_mask  <= w_mask_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_int   <= (w_state_nxt == ASSERT);
            r_state <= w_state_nxt;
        end
    end

    // Read data: valid flag plus grant ID while asserting, zero otherwise.
    always_comb begin
        iodata = 8'h00;
        if (sel && (r_state == ASSERT)) begin
            iodata[IDW-1:0]  = r_grant;
            iodata[VALID_BIT] = 1'b1;
        end
    end

    assign intr = r_int;

endmodule : irq_arbiter
`default_nettype wire
